// File: rtl/accel_reduce_mc.sv
// Multi-channel streaming reduction engine: per-channel SUM/MAX/MIN/SUMSQ accumulators
// fed by a two-stage pipeline, with results queued in an output FIFO.
module accel_reduce_mc #(
  parameter int DW    = 32,
  parameter int AW    = 48,
  parameter int CW    = 2,
  parameter int DEPTH = 8,
  parameter int NW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     soft_clear,
  input  logic [1:0]               cfg_mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW-1:0]            in_data,
  input  logic [CW-1:0]            in_chan,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW-1:0]            out_data,
  output logic [CW-1:0]            out_chan,
  output logic [NW-1:0]            out_count,
  output logic                     out_sat,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int NCH = 1 << CW;
  localparam int PW  = 2 * DW;
  localparam int SW  = (PW > AW) ? PW : AW;
  localparam int FAW = $clog2(DEPTH);
  localparam logic [AW-1:0]  ACC_MAX = '1;
  localparam logic [FAW+1:0] DEPTH_W = (FAW + 2)'(DEPTH);

  typedef enum logic [1:0] {
    MODE_SUM   = 2'd0,
    MODE_MAX   = 2'd1,
    MODE_MIN   = 2'd2,
    MODE_SUMSQ = 2'd3
  } mode_e;

  typedef struct packed {
    logic [CW-1:0] chan;
    logic [AW-1:0] data;
    logic [NW-1:0] count;
    logic          sat;
  } entry_t;

  logic          s1_valid_q, s1_last_q;
  logic [CW-1:0] s1_chan_q;
  mode_e         s1_mode_q;
  logic [DW-1:0] s1_data_q;
  logic [PW-1:0] s1_sq_q;

  logic [AW-1:0] acc_q    [NCH];
  logic [NW-1:0] cnt_q    [NCH];
  logic          sat_q    [NCH];
  mode_e         mode_q   [NCH];
  logic          active_q [NCH];

  entry_t        mem_q [DEPTH];
  logic [FAW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FAW:0]   count_q;

  logic          accept, push, pop;
  logic [FAW+1:0] occupancy;

  // Reserve a FIFO slot for a last beat still sitting in S1 so nothing can be dropped.
  assign occupancy = {1'b0, count_q} + {{(FAW + 1){1'b0}}, s1_valid_q & s1_last_q};
  assign in_ready  = rst_n && !soft_clear && (occupancy < DEPTH_W);
  assign accept    = in_valid && in_ready;

  // The square is always formed, since an active SUMSQ burst needs it even when
  // cfg_mode has since moved on.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_chan_q  <= '0;
      s1_mode_q  <= MODE_SUM;
      s1_data_q  <= '0;
      s1_sq_q    <= '0;
    end else if (soft_clear) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_chan_q  <= '0;
      s1_mode_q  <= MODE_SUM;
      s1_data_q  <= '0;
      s1_sq_q    <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_last_q <= in_last;
        s1_chan_q <= in_chan;
        s1_mode_q <= mode_e'(cfg_mode);
        s1_data_q <= in_data;
        s1_sq_q   <= PW'(in_data) * PW'(in_data);
      end
    end
  end

  logic          s2_active;
  mode_e         s2_mode;
  logic [SW-1:0] sq_w;
  logic [AW-1:0] op, acc_cur, nxt_acc;
  logic [AW:0]   sum_w;
  logic [NW-1:0] cnt_cur, nxt_cnt;
  logic          op_sat, sat_cur, nxt_sat;

  // NOTE: every combinational output gets a default before any branch so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    s2_active = active_q[s1_chan_q];
    s2_mode   = s2_active ? mode_q[s1_chan_q] : s1_mode_q;
    acc_cur   = acc_q[s1_chan_q];
    cnt_cur   = cnt_q[s1_chan_q];
    sat_cur   = sat_q[s1_chan_q];
    sq_w      = SW'(s1_sq_q);
    op        = AW'(s1_data_q);
    op_sat    = 1'b0;
    if (s2_mode == MODE_SUMSQ) begin
      if (sq_w > SW'(ACC_MAX)) begin
        op     = ACC_MAX;
        op_sat = 1'b1;
      end else begin
        op = sq_w[AW-1:0];
      end
    end
    sum_w   = {1'b0, acc_cur} + {1'b0, op};
    nxt_acc = op;
    nxt_cnt = NW'(1);
    nxt_sat = op_sat;
    if (s2_active) begin
      nxt_sat = sat_cur | op_sat | (&cnt_cur);
      nxt_cnt = (&cnt_cur) ? cnt_cur : cnt_cur + NW'(1);
      unique case (s2_mode)
        MODE_MAX: nxt_acc = (op > acc_cur) ? op : acc_cur;
        MODE_MIN: nxt_acc = (op < acc_cur) ? op : acc_cur;
        default: begin
          nxt_acc = sum_w[AW] ? ACC_MAX : sum_w[AW-1:0];
          nxt_sat = nxt_sat | sum_w[AW];
        end
      endcase
    end
  end

  // NOTE: the per-channel arrays and FIFO storage are small flop arrays, not RAM
  // macros, so clearing them on reset is cheap and makes out_* deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0; cnt_q[i] <= '0; sat_q[i] <= 1'b0;
        mode_q[i] <= MODE_SUM; active_q[i] <= 1'b0;
      end
    end else if (soft_clear) begin
      for (int i = 0; i < NCH; i++) begin
        acc_q[i] <= '0; cnt_q[i] <= '0; sat_q[i] <= 1'b0;
        mode_q[i] <= MODE_SUM; active_q[i] <= 1'b0;
      end
    end else if (s1_valid_q) begin
      acc_q[s1_chan_q]    <= nxt_acc;
      cnt_q[s1_chan_q]    <= nxt_cnt;
      sat_q[s1_chan_q]    <= nxt_sat;
      mode_q[s1_chan_q]   <= s2_mode;
      active_q[s1_chan_q] <= !s1_last_q;
    end
  end

  assign push = s1_valid_q && s1_last_q;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (soft_clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{chan: s1_chan_q, data: nxt_acc, count: nxt_cnt, sat: nxt_sat};
        wr_ptr_q        <= wr_ptr_q + FAW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + FAW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (FAW + 1)'(1);
        2'b01:   count_q <= count_q - (FAW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q].data;
  assign out_chan   = mem_q[rd_ptr_q].chan;
  assign out_count  = mem_q[rd_ptr_q].count;
  assign out_sat    = mem_q[rd_ptr_q].sat;
  assign fifo_count = count_q;

endmodule
